// File: rtl/ttt_pkg.sv
// Shared types, result codes, winning lines and cursor helpers for the tic-tac-toe turn sequencer.
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        PLAY,
        CHECK,
        DONE
    } state_t;

    // Cell k occupies board[k]; row-major, cell 0 is the top-left corner.
    typedef logic [8:0][1:0] board_t;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [3:0] first_empty(board_t b);
        logic [3:0] res;
        res = 4'd0;
        for (int k = 8; k >= 0; k--) begin
            if (b[k] == EMPTY) res = 4'(k);
        end
        return res;
    endfunction

    // Descending scan so the nearest empty cell after cur (with wrap) wins; stays put if none.
    function automatic logic [3:0] next_empty(board_t b, logic [3:0] cur);
        logic [3:0] res;
        logic [4:0] idx;
        res = cur;
        for (int k = 8; k >= 1; k--) begin
            idx = {1'b0, cur} + 5'(k);
            if (idx > 5'd8) idx = idx - 5'd9;
            if (b[idx[3:0]] == EMPTY) res = idx[3:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line evaluator: flags a completed line owned by the mover and a full board.
module ttt_win_check
    import ttt_pkg::*;
(
    input  board_t board_i,
    input  cell_t  mover_i,
    output logic   win_o,
    output logic   full_o
);

    always_comb begin
        win_o  = 1'b0;
        full_o = 1'b1;
        for (int l = 0; l < 8; l++) begin
            if (board_i[WIN_LINES[l][0]] == mover_i &&
                board_i[WIN_LINES[l][1]] == mover_i &&
                board_i[WIN_LINES[l][2]] == mover_i) begin
                win_o = 1'b1;
            end
        end
        for (int k = 0; k < 9; k++) begin
            if (board_i[k] == EMPTY) full_o = 1'b0;
        end
    end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn sequencer: button edge detect, board register, win/draw judging.
// Define TTT_TIMEOUT_EN to build the per-turn timer that forces a move at the cursor.
module ttt_turn_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned TURN_TICKS = 750_000_000,
    parameter int unsigned TW         = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       next,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic [1:0] c,
    output logic [1:0] d,
    output logic [1:0] e,
    output logic [1:0] f,
    output logic [1:0] g,
    output logic [1:0] h,
    output logic [1:0] i,
    output logic [3:0] cursor,
    output logic       turn,
    output logic [1:0] result,
    output logic       timeout
);

    state_t     state_q, state_d;
    board_t     board_q, board_d;
    logic [3:0] cursor_q, cursor_d;
    logic       turn_q, turn_d;
    logic [1:0] result_q, result_d;
    logic       timeout_q, timeout_d;
    logic       sel_q, next_q;
    logic       sel_press, next_press, auto_move;
    logic       win, full;
    cell_t      mover;

    assign sel_press  = sel & ~sel_q;
    assign next_press = next & ~next_q;
    assign mover      = turn_q ? P2 : P1;

    ttt_win_check u_win_check (
        .board_i (board_q),
        .mover_i (mover),
        .win_o   (win),
        .full_o  (full)
    );

`ifdef TTT_TIMEOUT_EN
    logic [TW-1:0] timer_q, timer_d;

    assign auto_move = (state_q == PLAY) && !sel_press && (timer_q == TW'(TURN_TICKS - 1));

    always_comb begin
        timer_d = '0;
        if (state_q == PLAY && !sel_press && !auto_move) timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timer_q <= '0;
        else      timer_q <= timer_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(TW), 32'(TURN_TICKS)};
    assign auto_move  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        cursor_d  = cursor_q;
        turn_d    = turn_q;
        result_d  = result_q;
        timeout_d = 1'b0;
        unique case (state_q)
            PLAY: begin
                // A forced move is placed exactly like a sel press.
                if (sel_press || auto_move) begin
                    board_d[cursor_q] = mover;
                    timeout_d         = auto_move;
                    state_d           = CHECK;
                end else if (next_press) begin
                    cursor_d = next_empty(board_q, cursor_q);
                end
            end
            CHECK: begin
                if (win) begin
                    result_d = turn_q ? RES_P2 : RES_P1;
                    state_d  = DONE;
                end else if (full) begin
                    result_d = RES_DRAW;
                    state_d  = DONE;
                end else begin
                    turn_d   = ~turn_q;
                    cursor_d = first_empty(board_q);
                    state_d  = PLAY;
                end
            end
            DONE: begin
                if (sel_press) begin
                    board_d  = '0;
                    result_d = RES_NONE;
                    turn_d   = 1'b0;
                    cursor_d = 4'd0;
                    state_d  = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= PLAY;
            board_q   <= '0;
            cursor_q  <= 4'd0;
            turn_q    <= 1'b0;
            result_q  <= RES_NONE;
            timeout_q <= 1'b0;
            sel_q     <= 1'b0;
            next_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            cursor_q  <= cursor_d;
            turn_q    <= turn_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            sel_q     <= sel;
            next_q    <= next;
        end
    end

    assign a       = board_q[0];
    assign b       = board_q[1];
    assign c       = board_q[2];
    assign d       = board_q[3];
    assign e       = board_q[4];
    assign f       = board_q[5];
    assign g       = board_q[6];
    assign h       = board_q[7];
    assign i       = board_q[8];
    assign cursor  = cursor_q;
    assign turn    = turn_q;
    assign result  = result_q;
    assign timeout = timeout_q;

endmodule
